// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on reset generator. Holds all channel resets for
// HOLD_CYCLES edges after Reset falls, then releases CHANNELS resets one at a
// time every STAGGER_CYCLES edges and raises Running once the last one drops.
// Restart (synchronous, level) re-runs the whole sequence.
// Optional watchdog: define RESET_SEQUENCER_WATCHDOG_EN to re-run the sequence
// automatically when Kick is absent for WATCHDOG_CYCLES edges while in RUN.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 127,
  parameter int STAGGER_CYCLES  = 16,
  parameter int WATCHDOG_CYCLES = 1048576
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Restart,
  input  logic                Kick,
  output logic [CHANNELS-1:0] ChannelResets,
  output logic                Running,
  output logic [1:0]          Phase,
  output logic                WatchdogFired
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] PH_HOLD    = 2'd0;
  localparam logic [1:0] PH_RELEASE = 2'd1;
  localparam logic [1:0] PH_RUN     = 2'd2;

  localparam logic [CW-1:0] HOLD_TERM    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAGGER_TERM = CW'(STAGGER_CYCLES);
  localparam logic [IW-1:0] LAST_IDX     = IW'(CHANNELS - 1);

  localparam bit PARAMS_OK = (CHANNELS >= 1) && (CHANNELS <= 16) &&
                             (HOLD_CYCLES >= 1) && (STAGGER_CYCLES >= 1) &&
                             (WATCHDOG_CYCLES >= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("reset_sequencer: illegal parameters CHANNELS=%0d HOLD_CYCLES=%0d STAGGER_CYCLES=%0d WATCHDOG_CYCLES=%0d",
             CHANNELS, HOLD_CYCLES, STAGGER_CYCLES, WATCHDOG_CYCLES);
    end
  endgenerate

  logic [1:0]          phase_q, phase_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic                running_q, running_d;

  logic [CW-1:0]       count_inc;
  logic [CW-1:0]       count_term;
  logic [CHANNELS-1:0] release_mask;
  logic                wd_timeout;
  logic                restart_req;

  // One-hot mask selecting the channel that drops next.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign release_mask[gi] = (idx_q == IW'(gi));
    end
  endgenerate

  // A watchdog timeout behaves exactly like a one-cycle Restart.
  assign restart_req = Restart | wd_timeout;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_TERM = WW'(WATCHDOG_CYCLES);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_fired_q, wd_fired_d;
  logic [WW-1:0] wd_inc;

  assign wd_inc     = wd_cnt_q + WW'(1);
  // Kick on the terminal edge wins, so no timeout is raised then.
  assign wd_timeout = (phase_q == PH_RUN) && !Kick && (wd_inc == WD_TERM);

  // Watchdog counter: runs only in RUN, starts at zero on entry, cleared by Kick.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    wd_fired_d = wd_fired_q | wd_timeout;
    if ((phase_q != PH_RUN) || Restart || Kick || wd_timeout) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_inc;
    end
  end

  // Watchdog state; the fired flag is sticky until Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wd_cnt_q   <= '0;
      wd_fired_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_fired_q <= wd_fired_d;
    end
  end

  assign WatchdogFired = wd_fired_q;
`else
  logic unused_kick;
  assign unused_kick   = Kick;
  assign wd_timeout    = 1'b0;
  assign WatchdogFired = 1'b0;
`endif

  assign count_inc  = count_q + CW'(1);
  assign count_term = (phase_q == PH_HOLD) ? HOLD_TERM : STAGGER_TERM;

  // Sequencer next state: count to the phase's terminal value, drop one channel, advance.
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    idx_d     = idx_q;
    chan_d    = chan_q;
    running_d = running_q;
    if (restart_req) begin
      phase_d   = PH_HOLD;
      count_d   = '0;
      idx_d     = '0;
      chan_d    = '1;
      running_d = 1'b0;
    end else begin
      case (phase_q)
        PH_HOLD, PH_RELEASE: begin
          if (count_inc == count_term) begin
            chan_d  = chan_q & ~release_mask;
            count_d = '0;
            if (idx_q == LAST_IDX) begin
              phase_d   = PH_RUN;
              running_d = 1'b1;
            end else begin
              phase_d = PH_RELEASE;
              idx_d   = idx_q + IW'(1);
            end
          end else begin
            count_d = count_inc;
          end
        end
        PH_RUN: begin
          // Everything released; hold until Restart, watchdog or Reset.
        end
        default: begin
          // Unreachable encoding: recover by starting a fresh sequence.
          phase_d   = PH_HOLD;
          count_d   = '0;
          idx_d     = '0;
          chan_d    = '1;
          running_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state; Reset forces the hold state immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase_q   <= PH_HOLD;
      count_q   <= '0;
      idx_q     <= '0;
      chan_q    <= '1;
      running_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      chan_q    <= chan_d;
      running_q <= running_d;
    end
  end

  assign ChannelResets = chan_q;
  assign Running       = running_q;
  assign Phase         = phase_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on reset generator for the board top level. It holds downstream logic in reset for a programmable number of clocks after the external reset is released. It then releases CHANNELS reset outputs one at a time with a programmable stagger (for example BRAM/CPU core first, then peripherals, then IO), and flags Running once all channels are released. A synchronous Restart re-runs the whole sequence; an optional watchdog re-runs it automatically.

Parameters:
CHANNELS, 3, number of reset outputs; legal range 1..16.
HOLD_CYCLES, 127, clock edges from external reset release to release of channel 0; must be >= 1.
STAGGER_CYCLES, 16, clock edges between successive channel releases; must be >= 1.
WATCHDOG_CYCLES, 1048576, clock edges without Kick before the watchdog restarts the sequence; used only with the watchdog feature.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
Restart  in  1  synchronous request to re-run the sequence; level-sensitive.
Kick  in  1  watchdog service strobe; ignored without the watchdog feature.
ChannelResets  out  CHANNELS  active-high resets; bit i is released i-th.
Running  out  1  high when all channels are released.
Phase  out  2  state: 0=HOLD, 1=RELEASE, 2=RUN; 3 is never driven.
WatchdogFired  out  1  sticky flag, set on watchdog timeout.

Behaviour:
- Reset is asynchronous and active-high. The clock port is Clock and the reset port is Reset.
- While Reset is high, all outputs and state are held, asynchronously and immediately:
  - ChannelResets = all ones, Running = 0, Phase = HOLD.
  - Internal count = 0, channel index = 0, WatchdogFired = 0.
- Edge numbering: edge 1 is the first rising Clock edge with Reset low.
- HOLD:
  - count increments once per edge.
  - On the edge that makes count equal HOLD_CYCLES, ChannelResets[0] drops to 0 and count clears.
  - Next state is RELEASE, or RUN when CHANNELS = 1.
- RELEASE:
  - count increments once per edge.
  - On reaching STAGGER_CYCLES, the next channel bit drops, count clears, and the index advances.
  - Channel i drops on edge HOLD_CYCLES + i*STAGGER_CYCLES.
- RUN is entered on the same edge the last channel drops. Running rises on that edge; it is registered together with ChannelResets.
- Released channels never re-assert, except through Restart, the watchdog, or Reset.
- Restart (synchronous) high at any edge, in any state:
  - All ChannelResets go to 1, Running to 0, Phase to HOLD, count to 0, index to 0.
  - While Restart stays high the block stays in HOLD with count 0.
  - The first edge with Restart low counts as edge 1 of a new sequence.
  - WatchdogFired is not cleared.
- Reset asserted mid-sequence aborts immediately to the reset values; no partial state survives.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES) + 1). No wrap-around is possible because the counter clears at its terminal value.
- All outputs are direct flop outputs; there are no combinational paths from inputs to outputs.
- Illegal parameter values are caught by an elaboration-time check: simulation $error plus a generate-false guard.

Optional Feature:
- Macro: RESET_SEQUENCER_WATCHDOG_EN.
- With the macro defined:
  - A watchdog counter runs only in RUN. It clears on entry to RUN and on any edge with Kick high.
  - When the counter reaches WATCHDOG_CYCLES without a Kick, the block behaves exactly as for a one-cycle Restart: a full re-sequence starts and WatchdogFired sets to 1.
  - If Kick is high on the timeout edge, Kick wins and there is no timeout.
  - Kick is ignored in HOLD and RELEASE.
  - WatchdogFired clears only on Reset.
- Without the macro: the watchdog logic is absent, Kick is unused, and WatchdogFired is tied to 0.

Test Plan:
- Defaults; Reset high for 5 cycles, then low -> ChannelResets 3'b111 through edge 126; 3'b110 at edge 127; 3'b100 at edge 143; 3'b000 and Running = 1 with Phase = 2 at edge 159.
- CHANNELS=1, HOLD_CYCLES=1 -> ChannelResets = 0 and Running = 1 at edge 1; Phase goes 0 -> 2 directly.
- Defaults; Restart high for 3 cycles starting at edge 150 -> ChannelResets = 3'b111 and Running = 0 from edge 150; with Restart low from edge 153, channel 0 drops at edge 152+127 = 279.
- Defaults; Reset pulsed asynchronously mid-cycle at edge 140 -> outputs return to reset values before the next edge; the sequence restarts counting from the next edge after Reset falls.
- Watchdog enabled, WATCHDOG_CYCLES=8; Kick every 5 cycles in RUN -> Running stays 1 and WatchdogFired stays 0. Kicks stop -> on the 8th edge without Kick, WatchdogFired = 1 and ChannelResets = 3'b111; re-release follows the default timing.
- Watchdog enabled; Kick coincident with the timeout edge -> no restart. Kick held during HOLD -> no effect on timing.
